// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: multiply/divide opcodes, MDU states and helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIN  = 2'd2
    } mdu_state_t;

    localparam int unsigned MDU_ITER = 32;

    function automatic logic op_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude/sign extraction and final result sign correction for the MDU.
module mdu_sign_fix
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  mdu_op_t            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               a_neg,
    output logic               b_neg,
    input  mdu_op_t            res_op,
    input  logic               res_a_neg,
    input  logic               res_b_neg,
    input  logic [WIDTH-1:0]   raw_hi,
    input  logic [WIDTH-1:0]   raw_lo,
    output logic [WIDTH-1:0]   fix_hi,
    output logic [WIDTH-1:0]   fix_lo
);

    logic [2*WIDTH-1:0] prod;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = op_is_signed(op) & a[WIDTH-1];
        b_neg = op_is_signed(op) & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    always_comb begin
        prod   = {raw_hi, raw_lo};
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (op_is_div(res_op)) begin
            fix_lo = (res_a_neg ^ res_b_neg) ? -raw_lo : raw_lo;
            fix_hi = res_a_neg ? -raw_hi : raw_hi;
        end else if (res_a_neg ^ res_b_neg) begin
            {fix_hi, fix_lo} = -prod;
        end
    end

endmodule

// File: rtl/mips_mdu.sv
// Multicycle multiply/divide unit: 32-step shift-add multiply and restoring divide into HI/LO.
module mips_mdu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = MDU_ITER
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  mdu_op_t            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int unsigned CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mdu_state_t           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    mdu_op_t              op_q, op_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     fix_hi, fix_lo;
    logic [2*WIDTH-1:0]   step;
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH:0]       sum;
    logic                 accept;

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op        (op),
        .a         (a),
        .b         (b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .res_op    (op_q),
        .res_a_neg (a_neg_q),
        .res_b_neg (b_neg_q),
        .raw_hi    (step[2*WIDTH-1:WIDTH]),
        .raw_lo    (step[WIDTH-1:0]),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

    // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient}
    // for divide; both start as {0, mag_a}.
    always_comb begin
        rem  = acc_q[2*WIDTH-1:WIDTH-1];
        diff = rem[WIDTH-1:0] - mag_b_q;
        sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        if (op_is_div(op_q)) begin
            if (rem >= {1'b0, mag_b_q}) begin
                step = {diff, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step = {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step = {sum, acc_q[WIDTH-1:1]};
        end
    end

    assign accept = start && (state_q != MDU_RUN);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            MDU_IDLE, MDU_FIN: begin
                if (accept) begin
                    op_d    = op;
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    mag_b_d = mag_b;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    count_d = '0;
                    dbz_d   = 1'b0;
                    if (op_is_div(op) && (b == '0)) begin
                        state_d = MDU_FIN;
                        hi_d    = a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = MDU_RUN;
                    end
                end else if (state_q == MDU_FIN) begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_RUN: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    state_d = MDU_FIN;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            count_q <= '0;
            op_q    <= MDU_MULT;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            mag_b_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q == MDU_RUN);
    assign done        = (state_q == MDU_FIN);
    assign div_by_zero = dbz_q;

endmodule
